// File: rtl/conv_pool_seq.sv
// conv_pool_seq: runtime-configurable 2-D convolution sequencer with a 1-D
// max-pool stage on its output.
// It reads the image and the kernel from 1-cycle-latency memories, one tap
// per cycle. It accumulates signed products per output pixel in raster
// order, max-pools groups of pool_n consecutive results, and writes each
// pooled value to the output memory.
// Optional feature macro: BEST_LOC_EN. When it is defined, the block also
// reports the largest un-pooled result of the job and its (row, col).
module conv_pool_seq #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 9,
  parameter int ACC_W    = 21,
  parameter int DIM_W    = 9,
  parameter int IADDR_W  = 18,
  parameter int KADDR_W  = 10,
  parameter int OADDR_W  = 13,
  parameter int POOL_MAX = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [DIM_W-1:0]          img_h,
  input  logic [DIM_W-1:0]          img_w,
  input  logic [DIM_W-1:0]          ker_h,
  input  logic [DIM_W-1:0]          ker_w,
  input  logic [3:0]                pool_n,
  output logic                      busy,
  output logic                      done,
  output logic                      err_cfg,
  output logic                      img_en,
  output logic [IADDR_W-1:0]        img_addr,
  input  logic signed [DATA_W-1:0]  img_data,
  output logic                      ker_en,
  output logic [KADDR_W-1:0]        ker_addr,
  input  logic signed [COEF_W-1:0]  ker_data,
  output logic                      out_we,
  output logic [OADDR_W-1:0]        out_addr,
`ifdef BEST_LOC_EN
  output logic signed [ACC_W-1:0]   best_val,
  output logic [DIM_W-1:0]          best_row,
  output logic [DIM_W-1:0]          best_col,
`endif
  output logic signed [ACC_W-1:0]   out_data,
  output logic [OADDR_W-1:0]        out_count
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [3:0]         PMAX   = 4'(POOL_MAX);
  localparam logic [3:0]         P_ONE  = 4'd1;
  localparam logic [DIM_W-1:0]   D_ONE  = DIM_W'(1);
  localparam logic [IADDR_W-1:0] I_ONE  = IADDR_W'(1);
  localparam logic [KADDR_W-1:0] K_ONE  = KADDR_W'(1);
  localparam logic [OADDR_W-1:0] O_ONE  = OADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  // Full-precision signed product of one image sample and one coefficient.
  function automatic logic signed [PROD_W-1:0] tap_mul(
    input logic signed [DATA_W-1:0] a,
    input logic signed [COEF_W-1:0] b
  );
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    a_ext = PROD_W'(a);
    b_ext = PROD_W'(b);
    return a_ext * b_ext;
  endfunction

  // Sign-extend a product to accumulator width (the sum then wraps).
  function automatic logic signed [ACC_W-1:0] sext_prod(
    input logic signed [PROD_W-1:0] p
  );
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

  // Zero-extend a dimension into the image address space.
  function automatic logic [IADDR_W-1:0] dim_to_iaddr(input logic [DIM_W-1:0] d);
    return {{(IADDR_W-DIM_W){1'b0}}, d};
  endfunction

  state_t                    r_state;
  logic [DIM_W-1:0]          r_img_h, r_img_w, r_ker_h, r_ker_w;
  logic [3:0]                r_pool_n;
  logic [DIM_W-1:0]          r_oh_last, r_ow_last, r_kh_last, r_kw_last;
  logic [DIM_W-1:0]          r_r, r_c, r_i, r_j;
  logic [IADDR_W-1:0]        r_pix_base, r_row_base;
  logic                      r_tap_vld, r_tap_first;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_pool_max;
  logic [3:0]                r_pool_cnt;

  logic signed [ACC_W-1:0]   w_prod_ext;
  logic signed [ACC_W-1:0]   w_conv;
  logic signed [ACC_W-1:0]   w_pool_new;
  logic [3:0]                w_pool_cnt_nx;
  logic                      w_group_full;
  logic                      w_last_col, w_last_row, w_last_pix;
  logic                      w_last_j, w_last_tap;
  logic                      w_cfg_bad;
  logic [IADDR_W-1:0]        w_img_w_ext, w_next_pix;

  // Datapath: product of the data returned this cycle and the running sum.
  assign w_prod_ext    = sext_prod(tap_mul(img_data, ker_data));
  assign w_conv        = r_tap_first ? w_prod_ext : (r_acc + w_prod_ext);
  assign w_pool_new    = ((r_pool_cnt == 4'd0) || (w_conv > r_pool_max)) ? w_conv : r_pool_max;
  assign w_pool_cnt_nx = r_pool_cnt + P_ONE;
  assign w_group_full  = (w_pool_cnt_nx == r_pool_n);

  // Position tracking: end of kernel row / last tap / last output pixel.
  assign w_last_j   = (r_j == r_kw_last);
  assign w_last_tap = w_last_j && (r_i == r_kh_last);
  assign w_last_col = (r_c == r_ow_last);
  assign w_last_row = (r_r == r_oh_last);
  assign w_last_pix = w_last_col && w_last_row;

  // Moving to the next row start from the last column skips ker_w samples.
  assign w_img_w_ext = dim_to_iaddr(r_img_w);
  assign w_next_pix  = w_last_col ? (r_pix_base + dim_to_iaddr(r_ker_w))
                                  : (r_pix_base + I_ONE);

  assign w_cfg_bad = (r_ker_h == '0) || (r_ker_w == '0) ||
                     (r_ker_h > r_img_h) || (r_ker_w > r_img_w) ||
                     (r_pool_n == 4'd0) || (r_pool_n > PMAX);

  // Sequencer FSM with address generation, accumulation, pooling and writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_cfg     <= 1'b0;
      img_en      <= 1'b0;
      img_addr    <= '0;
      ker_en      <= 1'b0;
      ker_addr    <= '0;
      out_we      <= 1'b0;
      out_addr    <= '0;
      out_data    <= '0;
      out_count   <= '0;
      r_img_h     <= '0;
      r_img_w     <= '0;
      r_ker_h     <= '0;
      r_ker_w     <= '0;
      r_pool_n    <= '0;
      r_oh_last   <= '0;
      r_ow_last   <= '0;
      r_kh_last   <= '0;
      r_kw_last   <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_pix_base  <= '0;
      r_row_base  <= '0;
      r_tap_vld   <= 1'b0;
      r_tap_first <= 1'b0;
      r_acc       <= '0;
      r_pool_max  <= '0;
      r_pool_cnt  <= '0;
    end else begin
      done        <= 1'b0;
      out_we      <= 1'b0;
      r_tap_vld   <= (r_state == S_RUN);
      r_tap_first <= (r_state == S_RUN) && (r_i == '0) && (r_j == '0);
      if (r_tap_vld) begin
        r_acc <= w_conv;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_img_h   <= img_h;
            r_img_w   <= img_w;
            r_ker_h   <= ker_h;
            r_ker_w   <= ker_w;
            r_pool_n  <= pool_n;
            busy      <= 1'b1;
            err_cfg   <= 1'b0;
            out_count <= '0;
            r_state   <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_cfg_bad) begin
            err_cfg <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_oh_last  <= r_img_h - r_ker_h;
            r_ow_last  <= r_img_w - r_ker_w;
            r_kh_last  <= r_ker_h - D_ONE;
            r_kw_last  <= r_ker_w - D_ONE;
            r_r        <= '0;
            r_c        <= '0;
            r_i        <= '0;
            r_j        <= '0;
            r_pix_base <= '0;
            r_row_base <= '0;
            r_pool_cnt <= '0;
            img_en     <= 1'b1;
            ker_en     <= 1'b1;
            img_addr   <= '0;
            ker_addr   <= '0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_last_tap) begin
            img_en  <= 1'b0;
            ker_en  <= 1'b0;
            r_state <= S_FLUSH;
          end else begin
            ker_addr <= ker_addr + K_ONE;
            if (w_last_j) begin
              r_j        <= '0;
              r_i        <= r_i + D_ONE;
              r_row_base <= r_row_base + w_img_w_ext;
              img_addr   <= r_row_base + w_img_w_ext;
            end else begin
              r_j      <= r_j + D_ONE;
              img_addr <= img_addr + I_ONE;
            end
          end
        end
        S_FLUSH: begin
          r_pool_max <= w_pool_new;
          // A full group, or whatever is left after the last pixel, is written.
          if (w_group_full || w_last_pix) begin
            out_we     <= 1'b1;
            out_addr   <= out_count;
            out_data   <= w_pool_new;
            out_count  <= out_count + O_ONE;
            r_pool_cnt <= 4'd0;
          end else begin
            r_pool_cnt <= w_pool_cnt_nx;
          end
          if (w_last_pix) begin
            r_state <= S_DONE;
          end else begin
            if (w_last_col) begin
              r_c <= '0;
              r_r <= r_r + D_ONE;
            end else begin
              r_c <= r_c + D_ONE;
            end
            r_pix_base <= w_next_pix;
            r_row_base <= w_next_pix;
            img_addr   <= w_next_pix;
            ker_addr   <= '0;
            r_i        <= '0;
            r_j        <= '0;
            img_en     <= 1'b1;
            ker_en     <= 1'b1;
            r_state    <= S_RUN;
          end
        end
        S_DONE: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef BEST_LOC_EN
  logic r_best_first;

  // Track the largest un-pooled result; strict compare keeps the earliest tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_val     <= '0;
      best_row     <= '0;
      best_col     <= '0;
      r_best_first <= 1'b0;
    end else if ((r_state == S_IDLE) && start) begin
      best_val     <= '0;
      best_row     <= '0;
      best_col     <= '0;
      r_best_first <= 1'b1;
    end else if (r_state == S_FLUSH) begin
      if (r_best_first || (w_conv > best_val)) begin
        best_val <= w_conv;
        best_row <= r_r;
        best_col <= r_c;
      end
      r_best_first <= 1'b0;
    end
  end
`else
  // Best-location tracking is not built in this configuration.
`endif

endmodule

// File: tb/tb_conv_pool_seq.sv
// Directed testbench for conv_pool_seq: behavioural image/kernel memories,
// an output-write recorder, and a linear sequence of jobs with hand-computed
// expected results.
module tb_conv_pool_seq;

  logic               clk;
  logic               reset;
  logic               start;
  logic [8:0]         img_h, img_w, ker_h, ker_w;
  logic [3:0]         pool_n;
  logic               busy, done, err_cfg;
  logic               img_en, ker_en, out_we;
  logic [17:0]        img_addr;
  logic [9:0]         ker_addr;
  logic signed [7:0]  img_data;
  logic signed [8:0]  ker_data;
  logic [12:0]        out_addr, out_count;
  logic signed [20:0] out_data;
`ifdef BEST_LOC_EN
  logic signed [20:0] best_val;
  logic [8:0]         best_row, best_col;
`endif

  logic signed [7:0]  img_mem [0:63];
  logic signed [8:0]  ker_mem [0:15];

  logic [31:0]        wr_addr [0:255];
  logic [31:0]        wr_data [0:255];
  int                 wr_n;
  int                 img_rd_n;

  int n_assert;
  int n_fail;
  int ncyc;
  int wbase;
  int rbase;

  conv_pool_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .img_h     (img_h),
    .img_w     (img_w),
    .ker_h     (ker_h),
    .ker_w     (ker_w),
    .pool_n    (pool_n),
    .busy      (busy),
    .done      (done),
    .err_cfg   (err_cfg),
    .img_en    (img_en),
    .img_addr  (img_addr),
    .img_data  (img_data),
    .ker_en    (ker_en),
    .ker_addr  (ker_addr),
    .ker_data  (ker_data),
    .out_we    (out_we),
    .out_addr  (out_addr),
`ifdef BEST_LOC_EN
    .best_val  (best_val),
    .best_row  (best_row),
    .best_col  (best_col),
`endif
    .out_data  (out_data),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port read memories with one cycle of latency.
  always @(posedge clk) begin
    if (img_en) img_data <= img_mem[img_addr[5:0]];
    if (ker_en) ker_data <= ker_mem[ker_addr[3:0]];
  end

  // Record every output write and count image reads.
  initial begin
    wr_n     = 0;
    img_rd_n = 0;
  end
  always @(negedge clk) begin
    if (out_we && (wr_n < 256)) begin
      wr_addr[wr_n] = 32'(out_addr);
      wr_data[wr_n] = 32'(out_data);
      wr_n = wr_n + 1;
    end
    if (img_en) img_rd_n = img_rd_n + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_wr(input string tag, input int base, input int idx,
                          input int exp_addr, input int exp_data);
    logic [31:0] a;
    logic [31:0] d;
    a = (base + idx < wr_n) ? wr_addr[base + idx] : 32'hDEADBEEF;
    d = (base + idx < wr_n) ? wr_data[base + idx] : 32'hDEADBEEF;
    check({tag, "_addr"}, a, 32'(exp_addr));
    check({tag, "_data"}, d, 32'(exp_data));
  endtask

  task automatic start_job(input int h, input int w, input int kh, input int kw, input int pn);
    img_h  = 9'(h);
    img_w  = 9'(w);
    ker_h  = 9'(kh);
    ker_w  = 9'(kw);
    pool_n = 4'(pn);
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 64; k++) img_mem[k] = 8'(k + 1);
    for (int k = 0; k < 16; k++) ker_mem[k] = 9'sd1;
  endtask

  // 4x4 ramp image, 3x3 all-ones kernel, no pooling: 54,63,90,99.
  task automatic job_ramp_pool1(input string tag);
    wbase = wr_n;
    start_job(4, 4, 3, 3, 1);
    check({tag, "_busy_after_start"}, 32'(busy), 1);
    wait_done(ncyc);
    check({tag, "_done_latency"}, 32'(ncyc), 42);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy_at_done"}, 32'(busy), 0);
    check({tag, "_err"}, 32'(err_cfg), 0);
    check({tag, "_count"}, 32'(out_count), 4);
    check({tag, "_nwr"}, 32'(wr_n - wbase), 4);
    check_wr({tag, "_w0"}, wbase, 0, 0, 54);
    check_wr({tag, "_w1"}, wbase, 1, 1, 63);
    check_wr({tag, "_w2"}, wbase, 2, 2, 90);
    check_wr({tag, "_w3"}, wbase, 3, 3, 99);
`ifdef BEST_LOC_EN
    check({tag, "_best_val"}, 32'(best_val), 99);
    check({tag, "_best_row"}, 32'(best_row), 1);
    check({tag, "_best_col"}, 32'(best_col), 1);
`endif
    tick();
    check({tag, "_done_pulse"}, 32'(done), 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    img_h    = '0;
    img_w    = '0;
    ker_h    = '0;
    ker_w    = '0;
    pool_n   = '0;
    load_ramp();
    tick();
    tick();

    // Reset state.
    check("rst_busy",    32'(busy),      0);
    check("rst_done",    32'(done),      0);
    check("rst_err",     32'(err_cfg),   0);
    check("rst_img_en",  32'(img_en),    0);
    check("rst_ker_en",  32'(ker_en),    0);
    check("rst_out_we",  32'(out_we),    0);
    check("rst_out_cnt", 32'(out_count), 0);
    check("rst_out_dat", 32'(out_data),  0);
    reset = 1'b0;
    tick();

    // Scenario 1: no pooling.
    job_ramp_pool1("p1");

    // Scenario 2: pool of 2; inputs change after start and must be ignored.
    wbase = wr_n;
    start_job(4, 4, 3, 3, 2);
    img_w  = 9'd2;
    ker_w  = 9'd1;
    pool_n = 4'd1;
    wait_done(ncyc);
    check("p2_done",  32'(done),        1);
    check("p2_count", 32'(out_count),   2);
    check("p2_nwr",   32'(wr_n - wbase), 2);
    check_wr("p2_w0", wbase, 0, 0, 63);
    check_wr("p2_w1", wbase, 1, 1, 99);
    tick();

    // Scenario 3: pool of 3 with a partial trailing group; start while busy ignored.
    wbase = wr_n;
    start_job(4, 4, 3, 3, 3);
    for (int k = 0; k < 5; k++) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(ncyc);
    check("p3_done_latency", 32'(ncyc + 6), 42);
    check("p3_count", 32'(out_count),    2);
    check("p3_nwr",   32'(wr_n - wbase), 2);
    check_wr("p3_w0", wbase, 0, 0, 90);
    check_wr("p3_w1", wbase, 1, 1, 99);
    tick();
    check("p3_idle_busy", 32'(busy), 0);

    // Scenario 4: kernel wider than the image is rejected.
    wbase = wr_n;
    rbase = img_rd_n;
    start_job(4, 4, 3, 5, 1);
    wait_done(ncyc);
    check("e1_done_latency", 32'(ncyc), 1);
    check("e1_err",    32'(err_cfg),         1);
    check("e1_busy",   32'(busy),            0);
    check("e1_reads",  32'(img_rd_n - rbase), 0);
    check("e1_nwr",    32'(wr_n - wbase),    0);
    check("e1_count",  32'(out_count),       0);
    tick();
    check("e1_err_held", 32'(err_cfg), 1);

    // Scenario 5: pool size above the legal maximum is rejected.
    start_job(4, 4, 3, 3, 9);
    wait_done(ncyc);
    check("e2_done_latency", 32'(ncyc), 1);
    check("e2_err", 32'(err_cfg), 1);
    tick();

    // Scenario 6: 1x1 kernel of -1 over a 1x2 image {-128, 5}, pool of 2.
    img_mem[0] = -8'sd128;
    img_mem[1] = 8'sd5;
    ker_mem[0] = 9'h1FF;
    wbase = wr_n;
    start_job(1, 2, 1, 1, 2);
    check("n1_err_cleared", 32'(err_cfg), 0);
    wait_done(ncyc);
    check("n1_done_latency", 32'(ncyc), 6);
    check("n1_count", 32'(out_count),    1);
    check("n1_nwr",   32'(wr_n - wbase), 1);
    check_wr("n1_w0", wbase, 0, 0, 128);
    tick();

    // Scenario 7: 1x1 image with 1x1 kernel gives exactly one result.
    wbase = wr_n;
    start_job(1, 1, 1, 1, 1);
    wait_done(ncyc);
    check("s1_done_latency", 32'(ncyc), 4);
    check("s1_count", 32'(out_count), 1);
    check_wr("s1_w0", wbase, 0, 0, 128);
    tick();

    // Scenario 8: reset during the second pixel, then a clean rerun.
    load_ramp();
    start_job(4, 4, 3, 3, 1);
    for (int k = 0; k < 14; k++) tick();
    check("ab_running", 32'(img_en), 1);
    #2;
    reset = 1'b1;
    #1;
    check("ab_busy",   32'(busy),      0);
    check("ab_out_we", 32'(out_we),    0);
    check("ab_done",   32'(done),      0);
    check("ab_img_en", 32'(img_en),    0);
    check("ab_count",  32'(out_count), 0);
    tick();
    reset = 1'b0;
    tick();
    check("ab_no_done", 32'(done), 0);
    job_ramp_pool1("rr");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
